// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the RV32M divide-group controller.
//   DW            operand / result width
//   F3_*          funct3 encodings of DIV, DIVU, REM, REMU
//   DIV_ZERO_Q    quotient returned for a zero divisor (all ones)
//   INT_MIN       most negative signed value (signed-overflow dividend/quotient)
//   state_e       controller FSM states
//   res_sel_e     quotient / remainder result select
package div_pkg;

    localparam int unsigned DW = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [DW-1:0] DIV_ZERO_Q = '1;
    localparam logic [DW-1:0] INT_MIN    = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DRAIN
    } state_e;

    typedef enum logic {
        SEL_QUOT,
        SEL_REM
    } res_sel_e;

endpackage

// File: rtl/div_special.sv
// div_special: combinational decode of the RISC-V divide special cases.
//   funct3_i  M-extension funct3 (1xx = divide group)
//   rs1_i     dividend
//   rs2_i     divisor
//   hit_o     operands resolve without the divider core
//   result_o  architectural result when hit_o is set
//   sel_o     quotient / remainder select for the op
// Multiply-group funct3 values (0xx) never produce a hit, so the same
// decode can sit in front of the multiplier path.
module div_special
    import div_pkg::*;
(
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] rs1_i,
    input  logic [DW-1:0] rs2_i,
    output logic          hit_o,
    output logic [DW-1:0] result_o,
    output res_sel_e      sel_o
);

    logic is_div_grp;
    logic is_signed;
    logic is_rem;
    logic div_zero;
    logic sgn_ovf;

    always_comb begin
        is_div_grp = funct3_i[2];
        is_signed  = ~funct3_i[0];
        is_rem     = funct3_i[1];
        div_zero   = (rs2_i == '0);
        sgn_ovf    = is_signed && (rs1_i == INT_MIN) && (rs2_i == '1);

        sel_o    = is_rem ? SEL_REM : SEL_QUOT;
        hit_o    = 1'b0;
        result_o = '0;

        // Zero divisor takes priority over signed overflow.
        if (is_div_grp) begin
            if (div_zero) begin
                hit_o    = 1'b1;
                result_o = is_rem ? rs1_i : DIV_ZERO_Q;
            end else if (sgn_ovf) begin
                hit_o    = 1'b1;
                result_o = is_rem ? '0 : INT_MIN;
            end
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: execute-stage controller for DIV/DIVU/REM/REMU.
//   clk, rst                 clock; synchronous active-low reset
//   op_valid_i, funct3_i     decoded divide op in execute
//   rs1_i, rs2_i, rd_addr_i  operands and destination
//   flush_i                  pipeline kill of the current op
//   div_*_o                  operands, mode and start strobe to the divider core
//   div_quot_i, div_rem_i    core results
//   div_done_i, div_busy_i   core status
//   stall_o                  freeze upstream pipeline
//   wb_en_o/addr_o/data_o    one-cycle register writeback
// Special cases and a one-entry result cache complete one cycle after
// acceptance; everything else goes through the core.
module div_ctrl
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] rs1_i,
    input  logic [DW-1:0] rs2_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          flush_i,
    output logic [DW-1:0] div_dividend_o,
    output logic [DW-1:0] div_divisor_o,
    output logic          div_signed_o,
    output logic          div_en_o,
    input  logic [DW-1:0] div_quot_i,
    input  logic [DW-1:0] div_rem_i,
    input  logic          div_done_i,
    input  logic          div_busy_i,
    output logic          stall_o,
    output logic          wb_en_o,
    output logic [4:0]    wb_addr_o,
    output logic [DW-1:0] wb_data_o
);

    state_e        state_q;

    // Latched op
    logic [DW-1:0] op_a_q;
    logic [DW-1:0] op_b_q;
    logic          op_signed_q;
    logic          op_rem_q;

    // Writeback registers
    logic          wb_en_q;
    logic [4:0]    wb_addr_q;
    logic [DW-1:0] wb_data_q;

    // One-entry result cache
    logic          c_valid_q;
    logic [DW-1:0] c_a_q;
    logic [DW-1:0] c_b_q;
    logic          c_signed_q;
    logic [DW-1:0] c_quot_q;
    logic [DW-1:0] c_rem_q;

    logic          sp_hit;
    logic [DW-1:0] sp_result;
    res_sel_e      sp_sel;

    logic          in_signed;
    logic          c_hit_d;
    logic [DW-1:0] c_data_d;

    div_special u_special (
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .hit_o    (sp_hit),
        .result_o (sp_result),
        .sel_o    (sp_sel)
    );

    always_comb begin
        in_signed = ~funct3_i[0];
        c_hit_d   = c_valid_q && (rs1_i == c_a_q) && (rs2_i == c_b_q) &&
                    (in_signed == c_signed_q);
        c_data_d  = (sp_sel == SEL_REM) ? c_rem_q : c_quot_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_signed_q <= 1'b0;
            op_rem_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            c_valid_q   <= 1'b0;
            c_a_q       <= '0;
            c_b_q       <= '0;
            c_signed_q  <= 1'b0;
            c_quot_q    <= '0;
            c_rem_q     <= '0;
        end else begin
            wb_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_valid_i) begin
                        op_a_q      <= rs1_i;
                        op_b_q      <= rs2_i;
                        op_signed_q <= in_signed;
                        op_rem_q    <= (sp_sel == SEL_REM);
                        wb_addr_q   <= rd_addr_i;
                        if (sp_hit) begin
                            wb_data_q <= sp_result;
                            wb_en_q   <= 1'b1;
                            state_q   <= S_WB;
                        end else if (c_hit_d) begin
                            wb_data_q <= c_data_d;
                            wb_en_q   <= 1'b1;
                            state_q   <= S_WB;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush_i) begin
                        c_valid_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else if (!div_busy_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Flush beats a coincident done: nothing is cached or written.
                    if (flush_i) begin
                        c_valid_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else if (div_done_i) begin
                        c_valid_q  <= 1'b1;
                        c_a_q      <= op_a_q;
                        c_b_q      <= op_b_q;
                        c_signed_q <= op_signed_q;
                        c_quot_q   <= div_quot_i;
                        c_rem_q    <= div_rem_i;
                        wb_data_q  <= op_rem_q ? div_rem_i : div_quot_i;
                        wb_en_q    <= 1'b1;
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (!div_busy_i && !div_done_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The start strobe is qualified with the live busy/flush inputs so it
    // never fires into a busy core nor for an op killed in ISSUE.
    assign div_en_o       = (state_q == S_ISSUE) && !div_busy_i && !flush_i;
    assign div_dividend_o = op_a_q;
    assign div_divisor_o  = op_b_q;
    assign div_signed_o   = op_signed_q;

    assign stall_o = ((state_q == S_IDLE) && op_valid_i) ||
                     (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                     (state_q == S_DRAIN);

    // A flush in the writeback cycle kills the registered strobe.
    assign wb_en_o   = wb_en_q && !flush_i;
    assign wb_addr_o = wb_addr_q;
    assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] div_dividend, div_divisor;
    logic        div_signed, div_en;
    logic [31:0] core_quot = '0;
    logic [31:0] core_rem = '0;
    logic        core_done = 1'b0;
    logic        core_busy = 1'b0;
    logic        inj_done = 1'b0;
    logic        div_done;
    logic        stall_o, wb_en_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;

    int n_cmp = 0;
    int n_bad = 0;
    int en_pulses = 0;
    int en_bad = 0;

    int          core_cnt = 0;
    int          core_hold = 0;
    logic [31:0] tq, tr;

    assign div_done = core_done | inj_done;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid_i     (op_valid),
        .funct3_i       (funct3),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .rd_addr_i      (rd_addr),
        .flush_i        (flush),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_signed_o   (div_signed),
        .div_en_o       (div_en),
        .div_quot_i     (core_quot),
        .div_rem_i      (core_rem),
        .div_done_i     (div_done),
        .div_busy_i     (core_busy),
        .stall_o        (stall_o),
        .wb_en_o        (wb_en_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o)
    );

    // Divider core stand-in: 3 busy cycles, then done held for 2 cycles.
    function automatic void core_calc(input logic [31:0] a, input logic [31:0] b,
                                      input logic s, output logic [31:0] q,
                                      output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            core_busy <= 1'b0;
            core_done <= 1'b0;
            core_cnt  <= 0;
            core_hold <= 0;
        end else if (div_en) begin
            en_pulses <= en_pulses + 1;
            if (core_busy || div_done) en_bad <= en_bad + 1;
            core_calc(div_dividend, div_divisor, div_signed, tq, tr);
            core_quot <= tq;
            core_rem  <= tr;
            core_busy <= 1'b1;
            core_done <= 1'b0;
            core_cnt  <= 3;
        end else if (core_busy) begin
            if (core_cnt == 1) begin
                core_busy <= 1'b0;
                core_done <= 1'b1;
                core_hold <= 2;
            end
            core_cnt <= core_cnt - 1;
        end else if (core_done) begin
            if (core_hold == 1) core_done <= 1'b0;
            core_hold <= core_hold - 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one op and wait (bounded) for its writeback.
    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output logic [31:0] data,
                            output logic [4:0] addr, output int lat, output int ens,
                            output logic stall_ok, output logic got);
        int e0;
        e0 = en_pulses;
        op_valid = 1'b1;
        funct3 = f3;
        rs1 = a;
        rs2 = b;
        rd_addr = rd;
        got = 1'b0;
        lat = 0;
        stall_ok = 1'b1;
        data = '0;
        addr = '0;
        #1;
        if (!stall_o) stall_ok = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            lat++;
            if (wb_en_o) begin
                got = 1'b1;
                data = wb_data_o;
                addr = wb_addr_o;
                if (stall_o) stall_ok = 1'b0;
                op_valid = 1'b0;
            end else if (!stall_o) begin
                stall_ok = 1'b0;
            end
        end
        op_valid = 1'b0;
        ens = en_pulses - e0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (wb_en_o !== 1'b0) begin n_bad++; $display("FAIL rst_wb_en: got %b want 0", wb_en_o); end
        n_cmp++; if (div_en !== 1'b0) begin n_bad++; $display("FAIL rst_div_en: got %b want 0", div_en); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        n_cmp++; if (wb_data_o !== 32'd0) begin n_bad++; $display("FAIL rst_wb_data: got %h want 0", wb_data_o); end
        n_cmp++; if (wb_addr_o !== 5'd0) begin n_bad++; $display("FAIL rst_wb_addr: got %0d want 0", wb_addr_o); end
        n_cmp++; if ({div_dividend, div_divisor, div_signed} !== 65'd0) begin
            n_bad++; $display("FAIL rst_core_ops: got %h %h %b want 0", div_dividend, div_divisor, div_signed);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_core_div;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        drive_op(F3_DIV, 32'd20, 32'hFFFF_FFFD, 5'd5, d, ad, lat, ens, sok, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL core_div_wb: got no writeback want one"); end
        n_cmp++; if (d !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL core_div_data: got %h want fffffffa", d); end
        n_cmp++; if (ad !== 5'd5) begin n_bad++; $display("FAIL core_div_addr: got %0d want 5", ad); end
        n_cmp++; if (ens != 1) begin n_bad++; $display("FAIL core_div_en_pulses: got %0d want 1", ens); end
        n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL core_div_latency: got %0d want 6", lat); end
        n_cmp++; if (sok !== 1'b1) begin n_bad++; $display("FAIL core_div_stall: got bad stall want high until wb"); end
        tick();
        n_cmp++; if (wb_en_o !== 1'b0) begin n_bad++; $display("FAIL core_div_wb_one_cycle: got %b want 0", wb_en_o); end
    endtask

    task automatic test_cache_hit;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        drive_op(F3_REM, 32'd20, 32'hFFFF_FFFD, 5'd6, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL cache_rem_data: got %h want 2", d); end
        n_cmp++; if (ens != 0) begin n_bad++; $display("FAIL cache_rem_en_pulses: got %0d want 0", ens); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL cache_rem_latency: got %0d want 1", lat); end
        n_cmp++; if (ad !== 5'd6) begin n_bad++; $display("FAIL cache_rem_addr: got %0d want 6", ad); end
        tick();
        n_cmp++; if (wb_en_o !== 1'b0) begin n_bad++; $display("FAIL cache_rem_wb_one_cycle: got %b want 0", wb_en_o); end
    endtask

    task automatic test_div_zero;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        drive_op(F3_DIVU, 32'd7, 32'd0, 5'd7, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu_zero_data: got %h want ffffffff", d); end
        n_cmp++; if (lat != 1 || ens != 0) begin n_bad++; $display("FAIL divu_zero_path: got lat %0d ens %0d want 1 0", lat, ens); end
        tick();
        drive_op(F3_REMU, 32'd7, 32'd0, 5'd8, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd7) begin n_bad++; $display("FAIL remu_zero_data: got %h want 7", d); end
        n_cmp++; if (lat != 1 || ens != 0) begin n_bad++; $display("FAIL remu_zero_path: got lat %0d ens %0d want 1 0", lat, ens); end
        tick();
    endtask

    task automatic test_overflow;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        drive_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL ovf_rem_data: got %h want 0", d); end
        n_cmp++; if (lat != 1 || ens != 0) begin n_bad++; $display("FAIL ovf_rem_path: got lat %0d ens %0d want 1 0", lat, ens); end
        tick();
        drive_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_div_data: got %h want 80000000", d); end
        n_cmp++; if (lat != 1 || ens != 0) begin n_bad++; $display("FAIL ovf_div_path: got lat %0d ens %0d want 1 0", lat, ens); end
        tick();
    endtask

    task automatic test_flush_wait;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        op_valid = 1'b1;
        funct3 = F3_DIVU;
        rs1 = 32'd100;
        rs2 = 32'd7;
        rd_addr = 5'd11;
        tick();
        n_cmp++; if (div_en !== 1'b1) begin n_bad++; $display("FAIL flush_issue_en: got %b want 1", div_en); end
        tick();
        op_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (wb_en_o !== 1'b0 || stall_o !== 1'b1) begin
            n_bad++; $display("FAIL flush_wait_drain: got wb_en %b stall %b want 0 1", wb_en_o, stall_o);
        end
        // Offered during DRAIN: held until the core goes quiet, then issued.
        drive_op(F3_DIVU, 32'd50, 32'd5, 5'd12, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd10) begin n_bad++; $display("FAIL drain_divu_data: got %h want a", d); end
        n_cmp++; if (ens != 1) begin n_bad++; $display("FAIL drain_divu_en_pulses: got %0d want 1", ens); end
        n_cmp++; if (lat != 11) begin n_bad++; $display("FAIL drain_divu_latency: got %0d want 11", lat); end
        n_cmp++; if (sok !== 1'b1) begin n_bad++; $display("FAIL drain_divu_stall: got bad stall want high until wb"); end
        tick();
        drive_op(F3_REMU, 32'd100, 32'd7, 5'd13, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL flushed_remu_data: got %h want 2", d); end
        n_cmp++; if (ens != 1 || lat != 6) begin n_bad++; $display("FAIL flushed_remu_miss: got ens %0d lat %0d want 1 6", ens, lat); end
        tick();
    endtask

    task automatic test_flush_done;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        logic seen;
        seen = 1'b0;
        op_valid = 1'b1;
        funct3 = F3_REMU;
        rs1 = 32'd9;
        rs2 = 32'd4;
        rd_addr = 5'd14;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (div_done) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL flush_done_wait: got no done want done"); end
        op_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (wb_en_o !== 1'b0 || stall_o !== 1'b1) begin
            n_bad++; $display("FAIL flush_done_wins: got wb_en %b stall %b want 0 1", wb_en_o, stall_o);
        end
        // Previously cached 100/7 must now miss.
        drive_op(F3_DIVU, 32'd100, 32'd7, 5'd15, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd14) begin n_bad++; $display("FAIL inval_divu_data: got %h want e", d); end
        n_cmp++; if (ens != 1) begin n_bad++; $display("FAIL inval_divu_miss: got ens %0d want 1", ens); end
        tick();
        drive_op(F3_REMU, 32'd9, 32'd4, 5'd16, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL flushed_done_remu_data: got %h want 1", d); end
        n_cmp++; if (ens != 1) begin n_bad++; $display("FAIL flushed_done_remu_miss: got ens %0d want 1", ens); end
        tick();
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] d; logic [4:0] ad; int lat, ens; logic sok, got;
        op_valid = 1'b1;
        funct3 = F3_DIV;
        rs1 = 32'd1000;
        rs2 = 32'd3;
        rd_addr = 5'd17;
        tick();
        tick();
        rst = 1'b0;
        op_valid = 1'b0;
        tick();
        n_cmp++; if ({wb_en_o, div_en, stall_o, div_signed} !== 4'b0000) begin
            n_bad++; $display("FAIL rstwait_ctrl: got wb_en %b en %b stall %b sgn %b want 0", wb_en_o, div_en, stall_o, div_signed);
        end
        n_cmp++; if ({wb_data_o, wb_addr_o} !== 37'd0) begin
            n_bad++; $display("FAIL rstwait_wb: got data %h addr %0d want 0", wb_data_o, wb_addr_o);
        end
        n_cmp++; if ({div_dividend, div_divisor} !== 64'd0) begin
            n_bad++; $display("FAIL rstwait_ops: got %h %h want 0", div_dividend, div_divisor);
        end
        rst = 1'b1;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        n_cmp++; if (wb_en_o !== 1'b0 || stall_o !== 1'b0) begin
            n_bad++; $display("FAIL rstwait_stray_done: got wb_en %b stall %b want 0 0", wb_en_o, stall_o);
        end
        tick();
        n_cmp++; if (wb_en_o !== 1'b0) begin n_bad++; $display("FAIL rstwait_no_wb: got %b want 0", wb_en_o); end
        drive_op(F3_DIV, 32'd1000, 32'd3, 5'd18, d, ad, lat, ens, sok, got);
        n_cmp++; if (d !== 32'd333) begin n_bad++; $display("FAIL rstwait_next_data: got %h want 14d", d); end
        n_cmp++; if (ens != 1 || lat != 6) begin n_bad++; $display("FAIL rstwait_next_path: got ens %0d lat %0d want 1 6", ens, lat); end
        tick();
    endtask

    task automatic test_protocol;
        n_cmp++; if (en_bad != 0) begin n_bad++; $display("FAIL en_while_core_active: got %0d want 0", en_bad); end
    endtask

    initial begin
        test_reset();
        test_core_div();
        test_cache_hit();
        test_div_zero();
        test_overflow();
        test_flush_wait();
        test_flush_done();
        test_reset_in_wait();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage controller for the RV32M divide group (DIV, DIVU, REM, REMU), sitting directly upstream of the multi-cycle divider core. It accepts decoded divide ops from the pipeline and short-circuits the RISC-V special cases (divide-by-zero, signed overflow). Ops that need the core are issued to it, and the pipeline is stalled until the core completes. The selected quotient or remainder is then written back. A one-entry result cache lets a DIV/REM pair on identical operands complete without a second core run.

## Interface
- DW, 32, operand and result width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- op_valid_i  in  1  divide op present in execute
- funct3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  DW  dividend
- rs2_i  in  DW  divisor
- rd_addr_i  in  5  destination register
- flush_i  in  1  pipeline kill of the current op
- div_dividend_o  out  DW  operand to core, stable while core busy
- div_divisor_o  out  DW  operand to core
- div_signed_o  out  1  signed mode to core
- div_en_o  out  1  start strobe, exactly one cycle per issue
- div_quot_i  in  DW  core quotient
- div_rem_i  in  DW  core remainder
- div_done_i  in  1  core result valid; may stay high for more than one cycle
- div_busy_i  in  1  core computing
- stall_o  out  1  freeze upstream pipeline
- wb_en_o  out  1  writeback strobe, one cycle
- wb_addr_o  out  5  writeback register
- wb_data_o  out  DW  writeback value

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE, op_valid_i=1: latch rs1, rs2, funct3 and rd. Then take the first matching path:
  - divisor==0: result is quotient 0xFFFFFFFF (DIV/DIVU) or remainder rs1 (REM/REMU). Go to WB.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: result is quotient 0x80000000 or remainder 0. Go to WB.
  - Cache hit (valid, same rs1, rs2 and signedness): result is the cached quotient or remainder. Go to WB.
  - Otherwise go to ISSUE.
- ISSUE: div_en_o=1 for one cycle, operands driven from latches. Go to WAIT.
- WAIT: on the first cycle div_done_i=1, capture quotient and remainder into the cache, mark it valid, and go to WB.
- WB: wb_en_o=1 with the selected data. Next state is IDLE.
- Flush:
  - In ISSUE or WAIT: no writeback, cache marked invalid. Go to DRAIN.
  - In WB: writeback suppressed. Go to IDLE.
  - Ignored in IDLE.
- DRAIN: hold until div_busy_i=0 and div_done_i=0, then go to IDLE. A new op offered during DRAIN stays stalled.
- Signedness is funct3[0]==0; quotient vs remainder is funct3[1].
- No arithmetic is performed locally beyond the equality compares; all widths are DW.

## Timing
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and cache valid to 0.
  - Outputs go to: div_en_o 0, wb_en_o 0, stall_o 0, wb_data_o 0, wb_addr_o 0, div_dividend_o 0, div_divisor_o 0, div_signed_o 0.
  - Reset during WAIT abandons the op; the core is reset by the same rst.
- stall_o is combinational:
  - 1 in IDLE when op_valid_i=1.
  - 1 in ISSUE, WAIT and DRAIN.
  - 0 in WB, so upstream advances on the writeback cycle.
- Special-case and cache-hit latency: op accepted in cycle N, wb_en_o in cycle N+1.
- Core latency: div_en_o in N+1, WB on the cycle after div_done_i is first seen. Done cycles after the first are ignored.
- div_en_o is never asserted while div_busy_i=1. ISSUE waits in place if the core is busy.
- Simultaneous flush_i and div_done_i in WAIT: flush wins, no writeback, cache invalidated.

## Structure
- Shared package div_pkg holds:
  - funct3 constants F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - State encodings.
  - Constants DIV_ZERO_Q (all ones) and INT_MIN.
- One sub-module, div_special: combinational. It takes operands and funct3, and outputs hit, the special result, and the path select. It also serves the multiplier-side decode later.
- The cache (rs1, rs2, signed, quotient, remainder, valid) is inline registers in div_ctrl.

## Test plan
- DIV rs1=20, rs2=0xFFFFFFFD: one div_en_o pulse, stall until done, then wb_data 0xFFFFFFFA and wb_en for one cycle.
- REM with the same operands on the next op: no div_en_o, wb_data 2 one cycle after acceptance.
- DIVU rs1=7, rs2=0: wb_data 0xFFFFFFFF in cycle N+1, no div_en_o. REMU with the same operands gives 7.
- REM rs1=0x80000000, rs2=0xFFFFFFFF: wb_data 0. DIV with the same operands gives 0x80000000. Neither touches the core.
- flush_i in WAIT: no wb_en. The next DIVU is stalled through DRAIN until busy and done are low, then issued with the correct result; the following REMU on the flushed operands misses the cache.
- rst low for one cycle during WAIT, with a core done pulse arriving afterwards: all outputs 0, no wb_en; the next op runs normally.
